// File: rtl/panda_muldiv.sv
`timescale 1ns/1ps
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Latency: MUL* XLEN/MUL_STEP+2, DIV/REM XLEN+2, divide special cases 1 cycle from accept.
// Backpressure: ready_o only in IDLE; the result is held in DONE until ready_i; kill_i flushes.
module panda_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   b_q, b_d;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [TAG_W-1:0]  tag_out_q, tag_out_d;

  logic              accept;
  logic              a_signed_in, b_signed_in;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              b_zero, sgn_ovf, special_in;
  logic [XLEN-1:0]   special_res;

  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [2*XLEN-1:0]        mul_next;
  logic [XLEN:0]            rem_sh, rem_diff;
  logic [2*XLEN-1:0]        div_next;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fix_res;

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = res_q;
  assign tag_o    = tag_out_q;

  // Decode the incoming op: signedness, operand magnitudes and the divide corner cases.
  always_comb begin
    accept      = valid_i && (state_q == S_IDLE) && !kill_i;
    a_signed_in = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed_in = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    sa_in       = a_signed_in && op_a_i[XLEN-1];
    sb_in       = b_signed_in && op_b_i[XLEN-1];
    a_mag       = sa_in ? -op_a_i : op_a_i;
    b_mag       = sb_in ? -op_b_i : op_b_i;
    b_zero      = (op_b_i == '0);
    sgn_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) && (op_a_i == XMIN) && (op_b_i == '1);
    special_in  = op_i[2] && (b_zero || sgn_ovf);
    // op_i[1] distinguishes remainder from quotient within the divide group.
    if (b_zero) begin
      special_res = op_i[1] ? op_a_i : '1;
    end else begin
      special_res = op_i[1] ? '0 : op_a_i;
    end
  end

  // One iteration of shift-add multiply and of restoring divide.
  always_comb begin
    mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    for (int i = 0; i < MUL_STEP; i++) begin
      if (acc_q[i]) begin
        mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, b_q} << i);
      end
    end
    mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};

    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, b_q};
    if (rem_diff[XLEN]) begin
      div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix-up of the raw magnitude result and final half/quotient/remainder select.
  always_comb begin
    prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_s = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quo_s;
      default:                       fix_res = rem_s;
    endcase
  end

  // Next-state logic; a flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (special_in)   state_d = S_DONE;
          else if (op_i[2]) state_d = S_DIV;
          else              state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  // Datapath next values; nothing updates on a flush so outputs keep their last values.
  always_comb begin
    op_d      = op_q;
    tag_d     = tag_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    res_d     = res_q;
    tag_out_d = tag_out_q;
    if (!kill_i) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d  = op_i;
            tag_d = tag_i;
            b_d   = b_mag;
            acc_d = {{XLEN{1'b0}}, a_mag};
            cnt_d = op_i[2] ? DIV_LAST : MUL_LAST;
            sa_d  = sa_in;
            sb_d  = sb_in;
            if (special_in) begin
              res_d     = special_res;
              tag_out_d = tag_i;
            end
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q - 1'b1;
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q - 1'b1;
        end
        S_FIX: begin
          res_d     = fix_res;
          tag_out_d = tag_q;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      res_q     <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      res_q     <= res_d;
      tag_out_q <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_panda_muldiv.sv
`timescale 1ns/1ps
// Bench for panda_muldiv: arithmetic reference model feeding a scoreboard queue,
// with a negedge monitor checking latency, result, tag and DONE-state stability.
module tb_panda_muldiv;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1, valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b1;
  logic [2:0]  op_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic [4:0]  tag_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  logic        v4_i = 1'b0, kill4_i = 1'b0, rdy4_i = 1'b1;
  logic [2:0]  op4_i = '0;
  logic [31:0] a4_i = '0, b4_i = '0;
  logic [4:0]  tag4_i = 5'd9;
  logic        rdy4_o, val4_o;
  logic [31:0] res4_o;
  logic [4:0]  tag4_o;

  panda_muldiv #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i), .kill_i(kill_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o));

  panda_muldiv #(.XLEN(32), .MUL_STEP(4), .TAG_W(5)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(v4_i), .ready_o(rdy4_o), .op_i(op4_i),
    .op_a_i(a4_i), .op_b_i(b4_i), .tag_i(tag4_i), .kill_i(kill4_i), .valid_o(val4_o),
    .ready_i(rdy4_i), .result_o(res4_o), .tag_o(tag4_o));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, acc_cyc = 0;
  bit   hs_prev = 0;
  bit   rdy_rand = 0, rdy_fix = 1;

  // Reference: RV32M semantics from plain 64-bit and integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'h0, a};       ub = {32'h0, b};
    ia = a; ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int step);
    if (!op[2]) return 32 / step + 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept detection pushes the expected response; flush or reset drops anything in flight.
  always @(posedge clk) begin
    if (rst_i || kill_i) begin
      q.delete();
    end else if (valid_i && ready_o) begin
      exp_t e;
      e.res = model(op_i, op_a_i, op_b_i);
      e.tag = tag_i;
      e.lat = lat_of(op_i, op_a_i, op_b_i, 1);
      e.seen = 0;
      q.push_back(e);
      acc_cyc = cyc;
    end
    cyc++;
  end

  // Monitor: compare every DONE cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (hs_prev) begin
        check("post_handshake_ready_o", {63'b0, ready_o}, 64'd1);
        check("post_handshake_valid_o", {63'b0, valid_o}, 64'd0);
      end
      hs_prev = 0;
      if (valid_o) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_valid_o: got valid_o=1 result=%0h, expected no result", result_o);
        end else begin
          exp_t e;
          e = q[0];
          if (!e.seen) begin
            check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
            e.seen = 1;
            q[0] = e;
          end
          check("result", {32'b0, result_o}, {32'b0, e.res});
          check("tag", {59'b0, tag_o}, {59'b0, e.tag});
          check("ready_o_in_done", {63'b0, ready_o}, 64'd0);
          if (ready_i) begin
            void'(q.pop_front());
            hs_prev = 1;
          end
        end
      end
    end
  end

  // Consumer readiness: fixed level or random backpressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    int n = 0;
    while (!ready_o && n < 500) begin @(posedge clk); #1; n++; end
    if (!ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_wait: ready_o=0 after %0d cycles, expected 1", n);
    end
    valid_i = 1; op_i = op; op_a_i = a; op_b_i = b; tag_i = tg;
    @(posedge clk); #1;
    valid_i = 0; op_i = 3'($urandom); op_a_i = $urandom; op_b_i = $urandom; tag_i = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_and_check(input string tagname);
    rst_i = 1;
    @(posedge clk);
    @(negedge clk);
    check({tagname, "_ready_o"}, {63'b0, ready_o}, 64'd1);
    check({tagname, "_valid_o"}, {63'b0, valid_o}, 64'd0);
    check({tagname, "_result_o"}, {32'b0, result_o}, 64'd0);
    check({tagname, "_tag_o"}, {59'b0, tag_o}, 64'd0);
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  task automatic run4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0, t0;
    v4_i = 1; op4_i = op; a4_i = a; b4_i = b;
    @(posedge clk); #1;
    v4_i = 0; a4_i = $urandom; b4_i = $urandom;
    t0 = cyc;
    @(negedge clk);
    while (!val4_o && n < 100) begin @(negedge clk); n++; end
    check("step4_latency", 64'(cyc - t0 + 1), 64'(lat_of(op, a, b, 4)));
    check("step4_result", {32'b0, res4_o}, {32'b0, model(op, a, b)});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  dop [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] da  [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, -32'sd7, -32'sd7,
                              32'd100, 32'd100, 32'h1234_5678, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] db  [12] = '{-32'sd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int n;

    reset_and_check("reset");

    for (int i = 0; i < 12; i++) issue(dop[i], da[i], db[i], 5'(i + 3));
    drain();

    // Hold the result in DONE for several cycles with no consumer.
    rdy_fix = 0;
    @(posedge clk); #1;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21);
    n = 0;
    while (!valid_o && n < 100) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #1;
    check("hold_ready_o", {63'b0, ready_o}, 64'd0);
    check("hold_valid_o", {63'b0, valid_o}, 64'd1);
    rdy_fix = 1;
    drain();

    // Flush a multiply at iteration 10.
    issue(3'd0, 32'd12345, 32'd678, 5'd7);
    repeat (9) @(posedge clk);
    #1; kill_i = 1;
    @(posedge clk); #1; kill_i = 0;
    @(negedge clk);
    check("kill_ready_o", {63'b0, ready_o}, 64'd1);
    check("kill_valid_o", {63'b0, valid_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // A request coinciding with a flush is dropped.
    valid_i = 1; kill_i = 1; op_i = 3'd5; op_a_i = 32'd9; op_b_i = 32'd0;
    @(posedge clk); #1; valid_i = 0; kill_i = 0;
    @(negedge clk);
    check("kill_drop_ready_o", {63'b0, ready_o}, 64'd1);
    repeat (5) @(posedge clk);
    #1;

    // Randomised ops with random consumer backpressure.
    rdy_rand = 1;
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
        2: b = $urandom_range(1, 15);
        3: begin b = $urandom; a = $urandom_range(0, 255); end
        default: b = $urandom;
      endcase
      issue(op, a, b, 5'($urandom));
    end
    drain();
    rdy_rand = 0;
    rdy_fix = 1;
    @(posedge clk); #1;

    // Reset in the middle of a divide.
    issue(3'd4, 32'd1000, 32'd3, 5'd30);
    repeat (15) @(posedge clk);
    #1;
    reset_and_check("mid_div_reset");
    repeat (40) @(posedge clk);
    #1;

    // Four multiplier bits per cycle.
    run4(3'd1, 32'h8000_0000, 32'h8000_0000);
    run4(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run4(3'd0, 32'd7, -32'sd3);
    run4(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) run4(3'($urandom_range(0, 3)), $urandom, $urandom);
    run4(3'd4, -32'sd7, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
